// File: rtl/rsa_avalon_host.sv
// Avalon-MM master that feeds the RSA-256 core from a UART: loads n and e once,
// then per block reads a ciphertext, starts the core and transmits 31 result bytes.
module rsa_avalon_host #(
  parameter int RX_ADDR     = 0,
  parameter int TX_ADDR     = 1,
  parameter int STATUS_ADDR = 2,
  parameter int RRDY_BIT    = 7,
  parameter int TRDY_BIT    = 6,
  parameter int IN_BYTES    = 32,
  parameter int OUT_BYTES   = 31
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [2:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_e,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);

  typedef enum logic [2:0] {
    S_QUERY_RX  = 3'd0,
    S_GET_DATA  = 3'd1,
    S_WAIT_CALC = 3'd2,
    S_QUERY_TX  = 3'd3,
    S_SEND_DATA = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_N = 2'd0,
    PH_E = 2'd1,
    PH_A = 2'd2
  } phase_t;

  localparam logic [2:0] RX_A     = 3'(RX_ADDR);
  localparam logic [2:0] TX_A     = 3'(TX_ADDR);
  localparam logic [2:0] STATUS_A = 3'(STATUS_ADDR);
  localparam logic [5:0] IN_LAST  = 6'(IN_BYTES - 1);
  localparam logic [5:0] OUT_LAST = 6'(OUT_BYTES - 1);

  state_t         state_q, state_d;
  phase_t         phase_q, phase_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [255:0]   n_q, n_d, e_q, e_d, a_q, a_d, result_q, result_d;
  logic [2:0]     address_q, address_d;
  logic           read_q, read_d, write_q, write_d, start_q, start_d;
  logic [31:0]    writedata_q, writedata_d;
  logic           xfer_done_s;
  logic           unused_s;

  assign xfer_done_s = (read_q | write_q) & ~avm_waitrequest;
  assign unused_s    = ^{avm_readdata[31:8], i_core_result[255:248]};

  // Next-state, datapath and bus request computation
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    e_d         = e_q;
    a_d         = a_q;
    result_d    = result_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    writedata_d = writedata_q;
    start_d     = 1'b0;
    case (state_q)
      S_QUERY_RX: begin
        if (xfer_done_s && avm_readdata[RRDY_BIT]) begin
          state_d   = S_GET_DATA;
          address_d = RX_A;
        end else begin
          state_d   = S_QUERY_RX;
        end
      end
      S_GET_DATA: begin
        if (xfer_done_s) begin
          case (phase_q)
            PH_N:    n_d = {n_q[247:0], avm_readdata[7:0]};
            PH_E:    e_d = {e_q[247:0], avm_readdata[7:0]};
            PH_A:    a_d = {a_q[247:0], avm_readdata[7:0]};
            default: a_d = a_q;
          endcase
          address_d = STATUS_A;
          state_d   = S_QUERY_RX;
          if (cnt_q == IN_LAST) begin
            cnt_d = 6'd0;
            case (phase_q)
              PH_N:    phase_d = PH_E;
              PH_E:    phase_d = PH_A;
              default: begin
                // Ciphertext complete: bus goes idle while the core runs
                phase_d = PH_A;
                state_d = S_WAIT_CALC;
                read_d  = 1'b0;
                start_d = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          state_d = S_GET_DATA;
        end
      end
      S_WAIT_CALC: begin
        if (i_core_finished) begin
          // Pre-shift so the top byte of the register is always the next byte to send
          result_d  = {i_core_result[247:0], 8'h00};
          state_d   = S_QUERY_TX;
          address_d = STATUS_A;
          read_d    = 1'b1;
        end else begin
          state_d   = S_WAIT_CALC;
        end
      end
      S_QUERY_TX: begin
        if (xfer_done_s && avm_readdata[TRDY_BIT]) begin
          state_d     = S_SEND_DATA;
          address_d   = TX_A;
          read_d      = 1'b0;
          write_d     = 1'b1;
          writedata_d = {24'h000000, result_q[255:248]};
        end else begin
          state_d     = S_QUERY_TX;
        end
      end
      S_SEND_DATA: begin
        if (xfer_done_s) begin
          result_d  = {result_q[247:0], 8'h00};
          address_d = STATUS_A;
          read_d    = 1'b1;
          write_d   = 1'b0;
          if (cnt_q == OUT_LAST) begin
            cnt_d   = 6'd0;
            state_d = S_QUERY_RX;
          end else begin
            cnt_d   = cnt_q + 6'd1;
            state_d = S_QUERY_TX;
          end
        end else begin
          state_d = S_SEND_DATA;
        end
      end
      default: begin
        state_d   = S_QUERY_RX;
        address_d = STATUS_A;
        read_d    = 1'b1;
        write_d   = 1'b0;
      end
    endcase
  end

  // State, datapath and registered bus outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_QUERY_RX;
      phase_q     <= PH_N;
      cnt_q       <= 6'd0;
      n_q         <= 256'd0;
      e_q         <= 256'd0;
      a_q         <= 256'd0;
      result_q    <= 256'd0;
      address_q   <= STATUS_A;
      read_q      <= 1'b1;
      write_q     <= 1'b0;
      writedata_q <= 32'd0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      e_q         <= e_d;
      a_q         <= a_d;
      result_q    <= result_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      writedata_q <= writedata_d;
      start_q     <= start_d;
    end
  end

  assign avm_address   = address_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = writedata_q;
  assign o_core_start  = start_q;
  assign o_core_a      = a_q;
  assign o_core_e      = e_q;
  assign o_core_n      = n_q;

endmodule

// File: tb/tb_rsa_avalon_host.sv
// Bench for rsa_avalon_host: UART and core models plus directed steps with random data.
module tb_rsa_avalon_host;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   avm_address;
  logic         avm_read, avm_write;
  logic [31:0]  avm_readdata = 32'd0;
  logic [31:0]  avm_writedata;
  logic         avm_waitrequest = 1'b0;
  logic         o_core_start;
  logic [255:0] o_core_a, o_core_e, o_core_n;
  logic [255:0] i_core_result = 256'd0;
  logic         i_core_finished = 1'b0;

  int total = 0;
  int bad = 0;

  byte unsigned rx_q[$];
  logic [31:0]  tx_log[$];
  int wait_cfg = 0, rrdy_gap_cfg = 0, trdy_gap_cfg = 0;
  int stall = 0, rx_gap = 0, tx_gap = 0, calc_cnt = 0, starts = 0;
  int stab_err = 0, proto_err = 0;
  logic         last_rrdy = 1'b0, last_trdy = 1'b0, prev_stall = 1'b0;
  logic [36:0]  prev_bus = 37'd0;
  logic [255:0] snap_a = 256'd0, snap_e = 256'd0, snap_n = 256'd0;

  rsa_avalon_host dut (
    .i_clk(clk), .i_rst(rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_e(o_core_e), .o_core_n(o_core_n),
    .i_core_result(i_core_result), .i_core_finished(i_core_finished)
  );

  always #5 clk = ~clk;

  // UART slave response and core model, driven mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      avm_waitrequest <= 1'b0;
      i_core_finished <= 1'b0;
      calc_cnt        <= 0;
    end else begin
      avm_waitrequest <= (avm_read || avm_write) && (stall < wait_cfg);
      if (avm_address == 3'd2)
        avm_readdata <= {24'd0, (rx_q.size() != 0 && rx_gap == 0), (tx_gap == 0), 6'd0};
      else if (avm_address == 3'd0 && rx_q.size() != 0)
        avm_readdata <= {24'd0, rx_q[0]};
      else
        avm_readdata <= 32'd0;
      i_core_finished <= (calc_cnt == 1);
      if (o_core_start) begin
        starts   <= starts + 1;
        calc_cnt <= 300;
        snap_a   <= o_core_a;
        snap_e   <= o_core_e;
        snap_n   <= o_core_n;
      end else if (calc_cnt > 0) begin
        calc_cnt <= calc_cnt - 1;
      end
    end
  end

  // Transfer completion, request stability and handshake-order bookkeeping
  always @(posedge clk) begin
    if (rst) begin
      stall <= 0; prev_stall <= 1'b0; rx_gap <= 0; tx_gap <= 0;
      last_rrdy <= 1'b0; last_trdy <= 1'b0;
    end else begin
      if (prev_stall && prev_bus !== {avm_address, avm_read, avm_write, avm_writedata})
        stab_err <= stab_err + 1;
      prev_stall <= (avm_read || avm_write) && avm_waitrequest;
      prev_bus   <= {avm_address, avm_read, avm_write, avm_writedata};
      if ((avm_read || avm_write) && avm_waitrequest) begin
        stall <= stall + 1;
      end else if (avm_read || avm_write) begin
        stall <= 0;
        if (avm_read && !avm_write && avm_address == 3'd2) begin
          last_rrdy <= avm_readdata[7];
          last_trdy <= avm_readdata[6];
          if (rx_gap > 0) rx_gap <= rx_gap - 1;
          if (tx_gap > 0) tx_gap <= tx_gap - 1;
        end else if (avm_read && !avm_write && avm_address == 3'd0) begin
          if (!last_rrdy || rx_q.size() == 0) proto_err <= proto_err + 1;
          else void'(rx_q.pop_front());
          rx_gap    <= rrdy_gap_cfg;
          last_rrdy <= 1'b0;
        end else if (avm_write && !avm_read && avm_address == 3'd1) begin
          if (!last_trdy) proto_err <= proto_err + 1;
          tx_log.push_back(avm_writedata);
          tx_gap    <= trdy_gap_cfg;
          last_trdy <= 1'b0;
        end else begin
          proto_err <= proto_err + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"}, 256'(avm_address), 256'd2);
    chk({tag, "_read"}, 256'(avm_read), 256'd1);
    chk({tag, "_write"}, 256'(avm_write), 256'd0);
    chk({tag, "_wdata"}, 256'(avm_writedata), 256'd0);
    chk({tag, "_start"}, 256'(o_core_start), 256'd0);
    chk({tag, "_n"}, o_core_n, 256'd0);
    chk({tag, "_e"}, o_core_e, 256'd0);
    chk({tag, "_a"}, o_core_a, 256'd0);
  endtask

  task automatic push_word(input logic [255:0] w, input int nbytes);
    for (int k = 0; k < nbytes; k++) rx_q.push_back(8'((w >> (8 * (31 - k))) & 256'hFF));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_tx(input int count, input int budget, input string tag);
    for (int i = 0; i < budget && tx_log.size() < count; i++) @(posedge clk);
    #1;
    chk(tag, 256'(tx_log.size()), 256'(count));
  endtask

  task automatic wait_rx_empty(input int budget, input string tag);
    for (int i = 0; i < budget && rx_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, 256'(rx_q.size()), 256'd0);
  endtask

  // Reference: byte k of the transmitted stream is result[247-8k -: 8]
  task automatic check_tx(input logic [255:0] res, input int base, input string tag);
    for (int k = 0; k < 31; k++) begin
      if (tx_log.size() > base + k)
        chk(tag, 256'(tx_log[base + k]), (res >> (8 * (30 - k))) & 256'hFF);
    end
  endtask

  logic [255:0] n1, e1, a1, r1, a2, r2, n3, e3, n4;

  initial begin
    n1 = 256'hCA3586E7EA485F3B0A222A4C79F7DD12E85388ECCDEE4035940D774C029CF831;
    e1 = {32{8'h0F}};
    a1 = 256'd1;
    r1 = rand256();
    r1[255:240] = 16'h00AB;
    r1[7:0]     = 8'hEF;

    repeat (3) @(posedge clk);
    #1 check_reset("rst0");
    @(negedge clk) rst = 1'b0;

    // Block 1: key and ciphertext with no stalls
    i_core_result = r1;
    push_word(n1, 32); push_word(e1, 32); push_word(a1, 32);
    wait_tx(31, 20000, "t1_tx_count");
    chk("t1_starts", 256'(starts), 256'd1);
    chk("t1_snap_n", snap_n, n1);
    chk("t1_snap_e", snap_e, e1);
    chk("t1_snap_a", snap_a, a1);
    if (tx_log.size() > 30) begin
      chk("t1_first", 256'(tx_log[0]), 256'h000000AB);
      chk("t1_last", 256'(tx_log[30]), 256'h000000EF);
    end
    check_tx(r1, 0, "t1_tx_byte");
    repeat (3) @(negedge clk);
    chk("t1_poll_addr", 256'(avm_address), 256'd2);
    chk("t1_poll_read", 256'(avm_read), 256'd1);
    chk("t1_poll_write", 256'(avm_write), 256'd0);

    // Block 2: stalls on every transfer and slow RRDY/TRDY
    wait_cfg = 5; rrdy_gap_cfg = 20; trdy_gap_cfg = 10;
    a2 = rand256();
    r2 = rand256();
    i_core_result = r2;
    push_word(a2, 32);
    wait_tx(62, 60000, "t2_tx_count");
    chk("t2_starts", 256'(starts), 256'd2);
    chk("t2_snap_n", snap_n, n1);
    chk("t2_snap_e", snap_e, e1);
    chk("t2_snap_a", snap_a, a2);
    check_tx(r2, 31, "t2_tx_byte");
    chk("t2_stable", 256'(stab_err), 256'd0);
    chk("t2_proto", 256'(proto_err), 256'd0);

    // Reset, then reset again part-way through e
    wait_cfg = 0; rrdy_gap_cfg = 0; trdy_gap_cfg = 0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset("rst1");
    @(negedge clk) rst = 1'b0;
    n3 = rand256();
    e3 = rand256();
    push_word(n3, 32); push_word(e3, 17);
    wait_rx_empty(5000, "t3_rx_drained");
    repeat (10) @(posedge clk);
    #1;
    chk("t3_n", o_core_n, n3);
    chk("t3_e_partial", o_core_e, e3 >> 120);
    #1 rst = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk) rst = 1'b0;
    n4 = rand256();
    push_word(n4, 32);
    wait_rx_empty(5000, "t4_rx_drained");
    repeat (10) @(posedge clk);
    #1;
    chk("t4_n", o_core_n, n4);
    chk("t4_e", o_core_e, 256'd0);
    chk("t4_starts", 256'(starts), 256'd2);
    chk("t4_proto", 256'(proto_err), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
